// File: rtl/fpu_pkg.sv
// Shared constants and field layout for the float-to-integer converter.
package fpu_pkg;

  localparam logic [7:0]  BIAS    = 8'd127;
  localparam logic [7:0]  EXP_OVF = 8'd158;
  localparam logic [7:0]  EXP_INT = 8'd150;  // BIAS + 23: significand is already an integer here
  localparam logic [31:0] INT_MAX = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN = 32'h80000000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float_t;

endpackage

// File: rtl/ftoi_shift.sv
// Barrel shifter aligning the 24-bit significand to an integer magnitude,
// truncating any fractional bits shifted out to the right.
module ftoi_shift
  import fpu_pkg::*;
(
  input  logic [23:0] sig_i,
  input  logic [7:0]  exp_i,
  output logic [31:0] mag_o
);

  logic [31:0] sigExt;
  assign sigExt = {8'b0, sig_i};

  // Out-of-range exponents still yield a defined value; the top masks them.
  always_comb begin
    mag_o = '0;
    if (exp_i >= EXP_INT) mag_o = sigExt << (exp_i - EXP_INT);
    else                  mag_o = sigExt >> (EXP_INT - exp_i);
  end

endmodule

// File: rtl/ftoi.sv
// Single-precision float to signed 32-bit integer, truncating toward zero,
// saturating on overflow, with one cycle of registered latency.
module ftoi
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  input  logic        in_valid,
  output logic [31:0] y,
  output logic        ovf,
  output logic        out_valid
);

  float_t      f;
  logic [31:0] mag;
  logic        isNan;
  logic [31:0] y_d, y_q;
  logic        ovf_d, ovf_q;
  logic        vld_q;

  assign f     = x;
  assign isNan = (f.exp == 8'hFF) && (f.man != '0);

  ftoi_shift u_shift (
    .sig_i ({1'b1, f.man}),
    .exp_i (f.exp),
    .mag_o (mag)
  );

  // NaN saturates positive regardless of sign; |x| < 1 collapses to zero.
  always_comb begin
    y_d   = '0;
    ovf_d = 1'b0;
    if (f.exp >= EXP_OVF) begin
      ovf_d = 1'b1;
      y_d   = (f.sign && !isNan) ? INT_MIN : INT_MAX;
    end else if (f.exp >= BIAS) begin
      y_d = f.sign ? (~mag + 32'd1) : mag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      y_q   <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        y_q   <= y_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign y         = y_q;
  assign ovf       = ovf_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_ftoi.sv
// Scoreboard bench for ftoi: driver queues expected results, a negedge
// monitor pops and compares them whenever out_valid is seen.
module tb_ftoi;

  logic        clk;
  logic        rstn;
  logic [31:0] x;
  logic        in_valid;
  logic [31:0] y;
  logic        ovf;
  logic        out_valid;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    int          due;
  } expect_t;

  expect_t     sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] lastY    = '0;
  logic        lastOvf  = 1'b0;
  logic [22:0] mans[8];

  ftoi dut (
    .clk       (clk),
    .rstn      (rstn),
    .x         (x),
    .in_valid  (in_valid),
    .y         (y),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic real pow2(input int n);
    real p = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) p = p * 2.0;
    else        for (int i = 0; i < -n; i++) p = p / 2.0;
    return p;
  endfunction

  // Reference built from the real value of the operand, not from shifting.
  task automatic model(input logic [31:0] xv, output logic [31:0] ey, output logic eo);
    int     e;
    real    r;
    integer t;
    e = int'(xv[30:23]);
    if (e == 255 && xv[22:0] != 0) begin
      ey = 32'h7FFFFFFF; eo = 1'b1;
    end else if (e >= 158) begin
      ey = xv[31] ? 32'h80000000 : 32'h7FFFFFFF; eo = 1'b1;
    end else if (e == 0) begin
      ey = 32'h0; eo = 1'b0;
    end else begin
      r  = (8388608.0 + real'(xv[22:0])) * pow2(e - 150);
      t  = $rtoi(r);
      ey = xv[31] ? -t : t;
      eo = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] xv, input logic [31:0] ey, input logic eo);
    expect_t ex;
    @(posedge clk);
    #1;
    x        = xv;
    in_valid = 1'b1;
    ex.y     = ey;
    ex.ovf   = eo;
    ex.due   = cyc + 1;
    sb.push_back(ex);
    lastY    = ey;
    lastOvf  = eo;
  endtask

  task automatic applyModel(input logic [31:0] xv);
    logic [31:0] ey;
    logic        eo;
    model(xv, ey, eo);
    applyStimulus(xv, ey, eo);
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare every presented result, flag results that never arrive.
  initial begin
    expect_t ex;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_output: got y=%h ovf=%b, required no output", y, ovf);
        end else begin
          ex = sb.pop_front();
          checkOutput("y", y, ex.y);
          checkOutput("ovf", {31'b0, ovf}, {31'b0, ex.ovf});
          checkOutput("latency_cycle", cyc, ex.due);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        ex = sb.pop_front();
        checks++; failures++;
        $display("[TB] FAIL missing_output: got out_valid=0, required y=%h ovf=%b", ex.y, ex.ovf);
      end
    end
  end

  initial begin
    mans[0] = 23'h000000; mans[1] = 23'h000001; mans[2] = 23'h000002; mans[3] = 23'h380000;
    mans[4] = 23'h400000; mans[5] = 23'h5FFFFF; mans[6] = 23'h7FFFFF; mans[7] = 23'h000000;

    rstn = 1'b0; in_valid = 1'b0; x = '0;
    #2;
    checkOutput("reset_y", y, 32'h0);
    checkOutput("reset_ovf", {31'b0, ovf}, 32'h0);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Hand-computed directed vectors, issued back to back.
    applyStimulus(32'h3F800000, 32'h00000001, 1'b0);
    applyStimulus(32'hBFC00000, 32'hFFFFFFFF, 1'b0);
    applyStimulus(32'h3F400000, 32'h00000000, 1'b0);
    applyStimulus(32'h80000000, 32'h00000000, 1'b0);
    applyStimulus(32'h4EFFFFFF, 32'h7FFFFF80, 1'b0);
    applyStimulus(32'h4F000000, 32'h7FFFFFFF, 1'b1);
    applyStimulus(32'hCF000000, 32'h80000000, 1'b1);
    applyStimulus(32'h7F800000, 32'h7FFFFFFF, 1'b1);
    applyStimulus(32'hFF800000, 32'h80000000, 1'b1);
    applyStimulus(32'hFFC00000, 32'h7FFFFFFF, 1'b1);
    applyStimulus(32'h00000001, 32'h00000000, 1'b0);
    applyStimulus(32'hC0490FDB, 32'hFFFFFFFD, 1'b0);
    applyStimulus(32'h4B000001, 32'h00800001, 1'b0);
    applyStimulus(32'hCEFFFFFF, 32'h80000080, 1'b0);
    idleCycle();
    repeat (2) @(negedge clk);
    checkOutput("idle_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("hold_y", y, lastY);
    checkOutput("hold_ovf", {31'b0, ovf}, {31'b0, lastOvf});

    for (int e = 1; e <= 254; e++) begin
      for (int s = 0; s < 2; s++) begin
        for (int m = 0; m < 8; m++) begin
          logic [22:0] mv;
          mv = (m == 7) ? 23'($urandom) : mans[m];
          applyModel({s[0], e[7:0], mv});
        end
      end
    end

    // Reset pulse while a result is in flight and another is queued.
    applyModel(32'h42F60000);
    applyModel(32'hC2F60000);
    applyModel(32'h47000000);
    #2;
    rstn     = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midreset_y", y, 32'h0);
    checkOutput("midreset_ovf", {31'b0, ovf}, 32'h0);
    checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    applyModel(32'h40400000);
    applyModel(32'hC0E00000);
    applyModel(32'h4F800000);
    applyModel(32'h3F7FFFFF);
    idleCycle();

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; failures++;
      $display("[TB] FAIL drain: got %0d pending results, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
